// File: rtl/quiz_round_ctrl.sv
// Round controller for the two-player arithmetic quiz: question sequencing, buzz-in arbitration,
// answer judging and scoring. Define QUIZ_PENALTY_EN to make wrong answers cost one point.
module quiz_round_ctrl #(
  parameter int NUM_Q          = 9,
  parameter int SCORE_W        = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int REVEAL_CYCLES  = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               bank_sel,
  input  logic [8:0]         joy_left,
  input  logic [8:0]         joy_right,
  input  logic [3:0]         correct_ans,
  output logic               q_bank,
  output logic [3:0]         q_index,
  output logic [2:0]         phase,
  output logic               buzz_left,
  output logic               buzz_right,
  output logic               result_valid,
  output logic               result_correct,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_LOAD = RW'(REVEAL_CYCLES - 1);
  localparam logic [3:0]    Q_LAST = 4'(NUM_Q - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_JUDGE  = 3'd2,
    S_REVEAL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q;
  logic               bank_q;
  logic [3:0]         idx_q;
  logic               buzz_l_q, buzz_r_q;
  logic               rv_q, rc_q;
  logic [SCORE_W-1:0] sl_q, sr_q;
  logic               go_q;
  logic [1:0]         win_q;
  logic               lock_l_q, lock_r_q;
  logic               prio_r_q;
  logic               any_l_q, any_r_q;
  logic [8:0]         ans_q;
  logic [TW-1:0]      timer_q;
  logic [RW-1:0]      rev_q;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] s);
    return (s == '0) ? s : s - SCORE_W'(1);
  endfunction

  // Rising-edge press detection; a held stick never fires twice.
  logic any_l, any_r, press_l, press_r, elig_l, elig_r, take_l, take_r;
  assign any_l   = |joy_left;
  assign any_r   = |joy_right;
  assign press_l = any_l & ~any_l_q;
  assign press_r = any_r & ~any_r_q;
  assign elig_l  = press_l & ~lock_l_q;
  assign elig_r  = press_r & ~lock_r_q;
  assign take_l  = elig_l & (~elig_r | ~prio_r_q);
  assign take_r  = elig_r & (~elig_l |  prio_r_q);

  // Out-of-range correct_ans shifts to zero and can never match a pressed vector.
  logic judge_ok, both_locked_nxt;
  assign judge_ok        = (ans_q == (9'd1 << (correct_ans - 4'd1)));
  assign both_locked_nxt = (lock_l_q | buzz_l_q) & (lock_r_q | buzz_r_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bank_q   <= 1'b0;
      idx_q    <= '0;
      buzz_l_q <= 1'b0;
      buzz_r_q <= 1'b0;
      rv_q     <= 1'b0;
      rc_q     <= 1'b0;
      sl_q     <= '0;
      sr_q     <= '0;
      go_q     <= 1'b0;
      win_q    <= 2'b00;
      lock_l_q <= 1'b0;
      lock_r_q <= 1'b0;
      prio_r_q <= 1'b0;
      any_l_q  <= 1'b0;
      any_r_q  <= 1'b0;
      ans_q    <= '0;
      timer_q  <= '0;
      rev_q    <= '0;
    end else begin
      any_l_q <= any_l;
      any_r_q <= any_r;
      rv_q    <= 1'b0;
      rc_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            bank_q   <= bank_sel;
            idx_q    <= '0;
            sl_q     <= '0;
            sr_q     <= '0;
            lock_l_q <= 1'b0;
            lock_r_q <= 1'b0;
            buzz_l_q <= 1'b0;
            buzz_r_q <= 1'b0;
            timer_q  <= '0;
            win_q    <= 2'b00;
            go_q     <= 1'b0;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (take_l | take_r) begin
            buzz_l_q <= take_l;
            buzz_r_q <= take_r;
            ans_q    <= take_l ? joy_left : joy_right;
            if (elig_l & elig_r) prio_r_q <= ~prio_r_q;
            // Saturate so a press on the timeout cycle cannot push the timer past its limit.
            if (timer_q != T_LAST) timer_q <= timer_q + TW'(1);
            state_q  <= S_JUDGE;
          end else if (timer_q == T_LAST) begin
            rv_q    <= 1'b1;
            rev_q   <= R_LOAD;
            state_q <= S_REVEAL;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_JUDGE: begin
          rv_q <= 1'b1;
          if (judge_ok) begin
            rc_q <= 1'b1;
            if (buzz_l_q) sl_q <= sat_inc(sl_q);
            if (buzz_r_q) sr_q <= sat_inc(sr_q);
            rev_q   <= R_LOAD;
            state_q <= S_REVEAL;
          end else begin
            lock_l_q <= lock_l_q | buzz_l_q;
            lock_r_q <= lock_r_q | buzz_r_q;
            buzz_l_q <= 1'b0;
            buzz_r_q <= 1'b0;
`ifdef QUIZ_PENALTY_EN
            if (buzz_l_q) sl_q <= sat_dec(sl_q);
            if (buzz_r_q) sr_q <= sat_dec(sr_q);
`endif
            if (both_locked_nxt) begin
              rev_q   <= R_LOAD;
              state_q <= S_REVEAL;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_REVEAL: begin
          if (rev_q == '0) begin
            buzz_l_q <= 1'b0;
            buzz_r_q <= 1'b0;
            lock_l_q <= 1'b0;
            lock_r_q <= 1'b0;
            timer_q  <= '0;
            if (idx_q == Q_LAST) begin
              go_q    <= 1'b1;
              state_q <= S_DONE;
              if (sl_q > sr_q)      win_q <= 2'b01;
              else if (sr_q > sl_q) win_q <= 2'b10;
              else                  win_q <= 2'b11;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= S_WAIT;
            end
          end else begin
            rev_q <= rev_q - RW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef QUIZ_PENALTY_EN
  logic unused_dec;
  assign unused_dec = ^sat_dec(sl_q);
`endif

  assign q_bank         = bank_q;
  assign q_index        = idx_q;
  assign phase          = state_q;
  assign buzz_left      = buzz_l_q;
  assign buzz_right     = buzz_r_q;
  assign result_valid   = rv_q;
  assign result_correct = rc_q;
  assign score_left     = sl_q;
  assign score_right    = sr_q;
  assign game_over      = go_q;
  assign winner         = win_q;

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Round controller for the two-player arithmetic quiz.
- Sequences the question index that addresses the question ROM and seven-segment display path.
- Arbitrates buzz-in answers from the left and right 9-position joysticks, judges them against the ROM's correct answer, and keeps both scores.
- Drives game-over and winner outputs after the last question.

Parameters:
- NUM_Q, 9, questions per game (1..16).
- SCORE_W, 5, score register width.
- TIMEOUT_CYCLES, 1000, answer window per question, in cycles of WAIT_ANS.
- REVEAL_CYCLES, 200, hold time for result display before advancing.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a game from IDLE or DONE.
- bank_sel  in  1  question-bank switch, sampled only on an accepted start.
- joy_left  in  9  left joystick, one bit per answer 1..9; synchronous, debounced.
- joy_right  in  9  right joystick, same encoding.
- correct_ans  in  4  correct answer from the question ROM for {q_bank,q_index}, combinational.
- q_bank  out  1  latched bank.
- q_index  out  4  current question, 0..NUM_Q-1.
- phase  out  3  FSM state: 0 IDLE, 1 WAIT_ANS, 2 JUDGE, 3 REVEAL, 4 DONE.
- buzz_left / buzz_right  out  1  player currently holding the answer; held through JUDGE/REVEAL.
- result_valid  out  1  one-cycle pulse per judged answer or timeout.
- result_correct  out  1  qualifies result_valid.
- score_left / score_right  out  SCORE_W  scores.
- game_over  out  1  high in DONE.
- winner  out  2  01 left, 10 right, 11 tie; 00 unless DONE.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, phase=IDLE, lockouts cleared, rr priority = left, timer 0.
- Press detection: any_x = OR of joy_x; press_x = any_x & ~any_x_q (registered previous any).
  - A joystick held across states never re-triggers.
  - Presses outside WAIT_ANS are discarded.
- Answer value: bit position+1. More than one bit set = wrong answer.
- IDLE/DONE + start:
  - Latch bank_sel → q_bank.
  - q_index=0, scores=0, lockouts clear, timer=0, winner=00, game_over=0.
  - Next state WAIT_ANS.
- start in any other state is ignored.
- WAIT_ANS:
  - Timer increments each cycle.
  - Eligible press (player not locked): latch player and value, set buzz_x, go JUDGE next cycle.
  - Both press in the same cycle, both eligible: player holding rr priority wins, then priority flips.
  - If only one player is eligible, that player wins with no priority change.
  - Timer reaching TIMEOUT_CYCLES-1 with no eligible press: go REVEAL, result_valid=1, result_correct=0, no buzz.
  - A press in the timeout cycle takes precedence over the timeout.
- JUDGE (1 cycle; timer paused):
  - Correct: that player's score +1, saturating at 2^SCORE_W-1; result_valid=1, result_correct=1; go REVEAL.
  - Wrong: lock that player for this question; result_valid=1, result_correct=0; clear buzz.
    - If the other player is unlocked, return to WAIT_ANS; timer resumes, not reset.
    - If both players are locked, go REVEAL.
- Latency: press sampled in cycle N → JUDGE in N+1 → result_valid and score update visible in N+2.
- REVEAL:
  - Counts REVEAL_CYCLES, then clears buzz, lockouts and timer.
  - If q_index==NUM_Q-1: go DONE and compute winner by score compare.
  - Otherwise: q_index+1 and go WAIT_ANS.
- DONE: game_over=1; scores and winner held until start or reset.
- rr priority persists across questions; reset only by rst_n.
- bank_sel changes mid-game have no effect.

Optional Feature:
- QUIZ_PENALTY_EN defined: a wrong answer also decrements that player's score, saturating at 0.
- Undefined: a wrong answer leaves the score unchanged. Lockout behaviour is identical in both cases.

Test Plan:
- Reset, start, bank_sel=1; left presses bit 3 with correct_ans=4 → q_bank=1, result_valid 2 cycles after the press, result_correct=1, score_left=1, REVEAL then q_index=1.
- Left and right press in the same cycle twice, on consecutive questions, both answers wrong → first judged player is left, second is right; all scores remain 0.
- Left wrong (bit 0, correct_ans=5), then right presses bit 4 → left locked, right's result_correct=1, score_right=1; a further left press before REVEAL is ignored.
- No press for TIMEOUT_CYCLES → result_valid with result_correct=0, q_index advances after REVEAL_CYCLES.
- Set TIMEOUT_CYCLES=5, REVEAL_CYCLES=1; left answers all 9 questions correctly, with score_left reaching 9 → game_over=1, winner=01; start restarts with scores at 0.
- Joystick held through REVEAL into the next WAIT_ANS → no buzz.
- Assert rst_n in JUDGE → all outputs 0, phase IDLE.
- With QUIZ_PENALTY_EN, a wrong answer at score 0 stays 0, and a wrong answer at score 2 gives 1.
